uart_param_parity: RTL and testbench
====================================

// Module: uart_param_parity
// PURPOSE
//  Full-duplex UART with runtime-selectable parity, parametrised data width, stop bits and FIFO depth.
//  Successor to the fixed 8-bit parity UART: adds odd/even/none parity select, frame and overrun
//  error detection, and per-word error flags stored in the RX FIFO.
//  Sits between the user bus (rd_uart/wr_uart FIFO handshake) and the serial pins tx/rx.
// PARAMETERS
//  DBIT    8   data bits per frame (5..9), LSB first
//  SB_TICK 16  stop-bit length in oversample ticks (16=1, 24=1.5, 32=2 stop bits)
//  DVSR    163 clk cycles per 16x oversample tick (baud = f_clk/(16*DVSR)); min 1
//  ADDR_W  2   FIFO address width; each FIFO holds 2**ADDR_W words
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  par_mode   in   2       00 none, 01 even, 10 odd, 11 none
//  rd_uart    in   1       pop RX FIFO head (single-cycle strobe)
//  wr_uart    in   1       push w_data into TX FIFO (single-cycle strobe)
//  w_data     in   DBIT    word to transmit
//  rx         in   1       serial input, idle high; double-flop synchronised internally
//  tx         out  1       serial output, idle high
//  tx_full    out  1       TX FIFO full
//  rx_empty   out  1       RX FIFO empty
//  r_data     out  DBIT    RX FIFO head data (valid while rx_empty=0)
//  par_err    out  1       parity error flag of RX FIFO head word
//  frm_err    out  1       stop-bit (framing) error flag of RX FIFO head word
//  overrun    out  1       sticky: a received word was dropped because RX FIFO was full
// BEHAVIOUR
//  Reset: tx=1, tx_full=0, rx_empty=1, r_data=0, par_err=0, frm_err=0, overrun=0; both FSMs IDLE,
//   FIFO pointers 0, tick counter 0. Reset mid-frame aborts the frame; tx returns to 1 immediately.
//  Tick gen: counter 0..DVSR-1, one-cycle tick when counter==DVSR-1, free-running from reset.
//  par_mode is latched at frame start (RX start detect / TX pop); changes mid-frame have no effect.
//  Parity bit present iff latched mode is 01/10; even: ^data^p==0, odd: ^data^p==1.
//  RX FSM IDLE->START->DATA->PARITY(opt)->STOP->IDLE:
//   IDLE: on synced rx==0 go START, clear tick count.
//   START: after 7 ticks resample; rx==1 -> IDLE (glitch, nothing pushed); rx==0 -> DATA.
//   DATA: sample every 16 ticks, shift in LSB first, DBIT samples.
//   PARITY: sample after 16 ticks, compute par_err. STOP: after SB_TICK ticks, frm_err = ~rx.
//   End of STOP: push {frm_err,par_err,data} (DBIT+2 bits) into RX FIFO, go IDLE.
//   Push while RX FIFO full (without same-cycle rd_uart): word dropped, overrun<=1.
//   overrun clears on the cycle after any rd_uart with rx_empty=0.
//  TX FSM IDLE->START->DATA->PARITY(opt)->STOP->IDLE:
//   IDLE: if TX FIFO non-empty, pop head and latch par_mode, go START (tx=0 for 16 ticks).
//   DATA: DBIT bits LSB first, 16 ticks each; PARITY 16 ticks; STOP tx=1 for SB_TICK ticks.
//   Back-to-back words: next pop on the IDLE cycle after STOP; no extra idle time required.
//  FIFOs: registered pointers, wrap mod 2**ADDR_W; full/empty from pointer compare + flag.
//   Write when full ignored; read when empty ignored. Simultaneous read+write when full: both
//   occur, stays full. Simultaneous read+write when empty: write only, empty deasserts next cycle.
//  Latency: wr_uart -> tx falling edge (start bit) within 2 clk + 1 tick when TX idle.
//   Last stop tick -> rx_empty=0 on next clk edge.
// CONFIGURATION
//  UART_LOOPBACK_EN defined: adds input port loopback (1 bit, after rx); when 1, RX FSM input is the
//   internal tx (pre-pin) and tx pin held at 1; when 0 normal operation.
//  UART_LOOPBACK_EN undefined: no loopback port; RX always uses rx pin. Behaviour otherwise identical.
// TESTING (DBIT=8, SB_TICK=16, DVSR=2, ADDR_W=2; 1 bit = 32 clk)
//  Reset then idle -> tx=1, rx_empty=1, tx_full=0, all error flags 0.
//  par_mode=01, write 8'hA5 -> tx: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each 32 clk.
//  par_mode=10, drive rx frame 8'h3C with parity 1 -> rx_empty=0, r_data=3C, par_err=0, frm_err=0;
//   same frame parity 0 -> par_err=1.
//  rx frame with stop bit 0 -> frm_err=1 on head; rx low pulse of 5 clk -> no word pushed.
//  Write 5 words back-to-back -> tx_full=1 after 4 (first pops to TX FSM, 4 queued; 6th ignored);
//   receive 5 frames without rd_uart -> 4 stored, overrun=1, cleared after one rd_uart.
//  With UART_LOOPBACK_EN, loopback=1, par_mode=01, write 8'h5A -> tx stays 1; r_data=5A, no errors.

Source files
------------

// File: rtl/uart_param_parity.sv
// rtl/uart_param_parity.sv - full-duplex UART with runtime parity select and error-flagged RX FIFO (option: UART_LOOPBACK_EN)

// Synchronous-write FIFO. Full and empty come from registered flags updated alongside the pointers.
module uart_pp_fifo #(
  parameter int W  = 10,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int N = 1 << AW;

  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] w_ptr_q, r_ptr_q;
  logic          full_q, empty_q;
  logic          wr_en, rd_en;

  // A write into a full FIFO is only accepted when a read frees the head slot in the same cycle
  assign wr_en   = wr_i & (~full_q | rd_i);
  assign rd_en   = rd_i & ~empty_q;
  assign rdata_o = mem_q[r_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Storage array, cleared on reset so the head reads as zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[w_ptr_q] <= wdata_i;
    end
  end

  // Pointer and flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          w_ptr_q <= w_ptr_q + AW'(1);
          empty_q <= 1'b0;
          full_q  <= ((w_ptr_q + AW'(1)) == r_ptr_q);
        end
        2'b01: begin
          r_ptr_q <= r_ptr_q + AW'(1);
          full_q  <= 1'b0;
          empty_q <= ((r_ptr_q + AW'(1)) == w_ptr_q);
        end
        2'b11: begin
          w_ptr_q <= w_ptr_q + AW'(1);
          r_ptr_q <= r_ptr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

module uart_param_parity #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int ADDR_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      par_mode,
  input  logic            rd_uart,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  input  logic            rx,
`ifdef UART_LOOPBACK_EN
  input  logic            loopback,
`endif
  output logic            tx,
  output logic            tx_full,
  output logic            rx_empty,
  output logic [DBIT-1:0] r_data,
  output logic            par_err,
  output logic            frm_err,
  output logic            overrun
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic          rx_meta_q, rx_sync_q, rx_in;
  logic          tx_bit_q, tx_bit_d;

  // Free-running oversample tick generator
  assign tick = (tick_cnt_q == CW'(DVSR - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + CW'(1);
  end

  // Two-flop synchroniser on the serial input; idles high so reset looks like line idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_bit_q : rx_sync_q;
  assign tx    = loopback ? 1'b1 : tx_bit_q;
`else
  assign rx_in = rx_sync_q;
  assign tx    = tx_bit_q;
`endif

  // ---------------- receiver ----------------
  state_t          rx_state_q, rx_state_d;
  logic [5:0]      rx_s_q, rx_s_d;
  logic [3:0]      rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic [1:0]      rx_mode_q, rx_mode_d;
  logic            rx_perr_q, rx_perr_d;
  logic            rx_push, rx_fifo_full;
  logic [DBIT+1:0] rx_word, rx_head;

  // Receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= S_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      rx_mode_q  <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      rx_mode_q  <= rx_mode_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // Receiver next state: mid-bit sampling, parity mode frozen at start detect
  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_mode_d  = rx_mode_q;
    rx_perr_d  = rx_perr_q;
    case (rx_state_q)
      S_IDLE:
        if (!rx_in) begin
          rx_state_d = S_START;
          rx_s_d     = '0;
          rx_mode_d  = par_mode;
          rx_perr_d  = 1'b0;
        end
      S_START:
        if (tick) begin
          if (rx_s_q == 6'd7) begin
            rx_s_d     = '0;
            rx_n_d     = '0;
            rx_state_d = rx_in ? S_IDLE : S_DATA;
          end else rx_s_d = rx_s_q + 6'd1;
        end
      S_DATA:
        if (tick) begin
          if (rx_s_q == 6'd15) begin
            rx_s_d = '0;
            rx_b_d = {rx_in, rx_b_q[DBIT-1:1]};
            if (rx_n_q == 4'(DBIT - 1)) rx_state_d = (^rx_mode_q) ? S_PAR : S_STOP;
            else                        rx_n_d     = rx_n_q + 4'd1;
          end else rx_s_d = rx_s_q + 6'd1;
        end
      S_PAR:
        if (tick) begin
          if (rx_s_q == 6'd15) begin
            rx_s_d     = '0;
            // mode 10 (odd) expects an odd total, so flip the even-parity result
            rx_perr_d  = (^rx_b_q) ^ rx_in ^ rx_mode_q[1];
            rx_state_d = S_STOP;
          end else rx_s_d = rx_s_q + 6'd1;
        end
      S_STOP:
        if (tick) begin
          if (rx_s_q == 6'(SB_TICK - 1)) rx_state_d = S_IDLE;
          else                           rx_s_d     = rx_s_q + 6'd1;
        end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Receiver outputs: push the finished word with its error flags on the last stop tick
  always_comb begin
    rx_push = (rx_state_q == S_STOP) && tick && (rx_s_q == 6'(SB_TICK - 1));
    rx_word = {~rx_in, rx_perr_q, rx_b_q};
  end

  uart_pp_fifo #(.W(DBIT + 2), .AW(ADDR_W)) u_rx_fifo (
    .clk(clk), .rst_n(reset), .wr_i(rx_push), .rd_i(rd_uart), .wdata_i(rx_word),
    .rdata_o(rx_head), .full_o(rx_fifo_full), .empty_o(rx_empty)
  );
  assign {frm_err, par_err, r_data} = rx_head;

  logic overrun_q;
  // Sticky overrun: set on a dropped word, cleared by any read of a non-empty FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  overrun_q <= 1'b0;
    else if (rd_uart && !rx_empty)               overrun_q <= 1'b0;
    else if (rx_push && rx_fifo_full && !rd_uart) overrun_q <= 1'b1;
  end
  assign overrun = overrun_q;

  // ---------------- transmitter ----------------
  state_t          tx_state_q, tx_state_d;
  logic [5:0]      tx_s_q, tx_s_d;
  logic [3:0]      tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_pon_q, tx_pon_d, tx_pbit_q, tx_pbit_d;
  logic            tx_pop, tx_fifo_empty;
  logic [DBIT-1:0] tx_head;

  uart_pp_fifo #(.W(DBIT), .AW(ADDR_W)) u_tx_fifo (
    .clk(clk), .rst_n(reset), .wr_i(wr_uart), .rd_i(tx_pop), .wdata_i(w_data),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_fifo_empty)
  );

  // Transmitter state register; the pin bit is registered so it never glitches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_pon_q   <= 1'b0;
      tx_pbit_q  <= 1'b0;
      tx_bit_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_pon_q   <= tx_pon_d;
      tx_pbit_q  <= tx_pbit_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  // Transmitter next state: parity bit is precomputed when the word is popped
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_pon_d   = tx_pon_q;
    tx_pbit_d  = tx_pbit_q;
    case (tx_state_q)
      S_IDLE:
        if (!tx_fifo_empty) begin
          tx_state_d = S_START;
          tx_s_d     = '0;
          tx_b_d     = tx_head;
          tx_pon_d   = ^par_mode;
          tx_pbit_d  = (^tx_head) ^ par_mode[1];
        end
      S_START:
        if (tick) begin
          if (tx_s_q == 6'd15) begin
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_state_d = S_DATA;
          end else tx_s_d = tx_s_q + 6'd1;
        end
      S_DATA:
        if (tick) begin
          if (tx_s_q == 6'd15) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == 4'(DBIT - 1)) tx_state_d = tx_pon_q ? S_PAR : S_STOP;
            else                        tx_n_d     = tx_n_q + 4'd1;
          end else tx_s_d = tx_s_q + 6'd1;
        end
      S_PAR:
        if (tick) begin
          if (tx_s_q == 6'd15) begin
            tx_s_d     = '0;
            tx_state_d = S_STOP;
          end else tx_s_d = tx_s_q + 6'd1;
        end
      S_STOP:
        if (tick) begin
          if (tx_s_q == 6'(SB_TICK - 1)) tx_state_d = S_IDLE;
          else                           tx_s_d     = tx_s_q + 6'd1;
        end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Transmitter outputs: FIFO pop in IDLE and the line level for the upcoming state
  always_comb begin
    tx_pop = (tx_state_q == S_IDLE) && !tx_fifo_empty;
    case (tx_state_d)
      S_START: tx_bit_d = 1'b0;
      S_DATA:  tx_bit_d = tx_b_d[0];
      S_PAR:   tx_bit_d = tx_pbit_d;
      default: tx_bit_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_param_parity.sv
// tb/tb_uart_param_parity.sv - scoreboard bench for uart_param_parity with a frame-level reference model
module tb_uart_param_parity;
  localparam int DBIT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] par_mode = 2'b00;
  logic       rd_uart = 1'b0, wr_uart = 1'b0;
  logic [7:0] w_data = '0;
  logic       rx = 1'b1;
  logic       tx, tx_full, rx_empty, par_err, frm_err, overrun;
  logic [7:0] r_data;

  uart_param_parity #(.DBIT(8), .SB_TICK(16), .DVSR(2), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .par_mode(par_mode), .rd_uart(rd_uart), .wr_uart(wr_uart),
    .w_data(w_data), .rx(rx), .tx(tx), .tx_full(tx_full), .rx_empty(rx_empty),
    .r_data(r_data), .par_err(par_err), .frm_err(frm_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: parity bit and serial frame from the protocol rules
  function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] m);
    return logic'(($countones(d) % 2) == 1) ^ (m == 2'b10);
  endfunction

  function automatic int ref_len(input logic [1:0] m);
    return (m == 2'b01 || m == 2'b10) ? 11 : 10;
  endfunction

  // bit i is the i-th bit on the line: start, data LSB first, optional parity, stop
  function automatic logic [11:0] ref_frame(input logic [7:0] d, input logic [1:0] m);
    logic [11:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    if (ref_len(m) == 11) begin
      f[9]  = ref_parity(d, m);
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  typedef struct { logic [7:0] d; logic [1:0] m; } tx_exp_t;
  typedef struct { logic [7:0] d; logic p; logic f; } rx_exp_t;
  tx_exp_t txq[$];
  rx_exp_t rxq[$];
  logic    tx_busy  = 1'b0;
  logic    auto_read = 1'b1;
  logic    exp_ovr  = 1'b0;

  // TX monitor: on a falling edge, pop the expected word and sample each bit mid-period
  initial begin
    logic        tx_prev;
    logic [11:0] got;
    tx_exp_t     e;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && tx_prev && !tx) begin
        if (txq.size() == 0) begin
          check("tx_unexpected_frame", 32'(1), 32'(0));
        end else begin
          tx_busy = 1'b1;
          e   = txq.pop_front();
          got = '0;
          repeat (16) @(negedge clk);
          got[0] = tx;
          for (int i = 1; i < ref_len(e.m); i++) begin
            repeat (32) @(negedge clk);
            got[i] = tx;
          end
          check("tx_frame", 32'(got), 32'(ref_frame(e.d, e.m)));
          tx_busy = 1'b0;
        end
      end
      tx_prev = tx;
    end
  end

  // RX monitor: whenever the FIFO presents a word, compare it with the oldest expected and pop it
  initial begin
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (reset && auto_read && !rx_empty) begin
        if (rxq.size() == 0) begin
          check("rx_unexpected_word", 32'(1), 32'(0));
        end else begin
          e = rxq.pop_front();
          check("rx_data", 32'(r_data), 32'(e.d));
          check("rx_par_err", 32'(par_err), 32'(e.p));
          check("rx_frm_err", 32'(frm_err), 32'(e.f));
        end
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
      end
    end
  end

  task automatic drive_bit(input logic b, input int ncyc);
    rx = b;
    repeat (ncyc) @(negedge clk);
  endtask

  // Serialise one frame on rx; the model decides whether the FIFO keeps or drops it
  task automatic send_rx(input logic [7:0] d, input logic [1:0] m, input logic bad_par,
                         input logic bad_stop);
    rx_exp_t e;
    logic    pon;
    pon = (ref_len(m) == 11);
    e.d = d;
    e.p = pon & bad_par;
    e.f = bad_stop;
    if (!auto_read && rxq.size() >= 4) exp_ovr = 1'b1;
    else rxq.push_back(e);
    par_mode = m;
    drive_bit(1'b0, 32);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 32);
    if (pon) drive_bit(ref_parity(d, m) ^ bad_par, 32);
    if (bad_stop) begin
      drive_bit(1'b0, 20);
      drive_bit(1'b1, 60);
    end else begin
      drive_bit(1'b1, 32);
    end
  endtask

  task automatic write_tx(input logic [7:0] d, input logic expect_kept);
    tx_exp_t e;
    w_data  = d;
    wr_uart = 1'b1;
    if (expect_kept) begin
      e.d = d;
      e.m = par_mode;
      txq.push_back(e);
    end
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int k;
    k = 0;
    while ((txq.size() != 0 || tx_busy) && k < 6000) begin
      @(negedge clk);
      k++;
    end
    repeat (40) @(negedge clk);
    check("tx_drained", 32'(txq.size() == 0 && !tx_busy), 32'(1));
  endtask

  task automatic wait_rx_drain();
    int k;
    k = 0;
    while ((rxq.size() != 0 || !rx_empty) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rx_drained", 32'(rxq.size() == 0 && rx_empty), 32'(1));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] m;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'(1));
    check("reset_rx_empty", 32'(rx_empty), 32'(1));
    check("reset_tx_full", 32'(tx_full), 32'(0));
    check("reset_r_data", 32'(r_data), 32'(0));
    check("reset_flags", 32'({par_err, frm_err, overrun}), 32'(0));
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_tx", 32'(tx), 32'(1));
    check("idle_rx_empty", 32'(rx_empty), 32'(1));
    check("idle_flags", 32'({tx_full, par_err, frm_err, overrun}), 32'(0));

    // TX: even parity on A5, then a mid-frame parity-mode change that must be ignored
    par_mode = 2'b01;
    write_tx(8'hA5, 1'b1);
    wait_tx_drain();
    write_tx(8'h3C, 1'b1);
    repeat (100) @(negedge clk);
    par_mode = 2'b10;
    wait_tx_drain();

    // TX: burst of five fills the FIFO after the first is taken; a sixth is dropped
    par_mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      write_tx(8'($urandom_range(0, 255)), 1'b1);
      check("tx_full_burst", 32'(tx_full), 32'(i == 4));
    end
    write_tx(8'hFF, 1'b0);
    check("tx_full_after_6th", 32'(tx_full), 32'(1));
    wait_tx_drain();
    check("tx_full_drained", 32'(tx_full), 32'(0));

    // TX: random words and parity modes
    for (int i = 0; i < 6; i++) begin
      par_mode = 2'($urandom_range(0, 3));
      write_tx(8'($urandom_range(0, 255)), 1'b1);
      wait_tx_drain();
    end

    // RX directed: odd parity good and bad, framing error, start glitch
    send_rx(8'h3C, 2'b10, 1'b0, 1'b0);
    send_rx(8'h3C, 2'b10, 1'b1, 1'b0);
    send_rx(8'h81, 2'b00, 1'b0, 1'b1);
    wait_rx_drain();
    auto_read = 1'b0;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 200);
    check("glitch_no_word", 32'(rx_empty), 32'(1));
    auto_read = 1'b1;

    // RX random frames
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      m = 2'($urandom_range(0, 3));
      send_rx(d, m, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    wait_rx_drain();

    // RX overrun: five frames with no reads, four stored
    auto_read = 1'b0;
    exp_ovr   = 1'b0;
    for (int i = 0; i < 5; i++) send_rx(8'($urandom_range(0, 255)), 2'b01, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("overrun_set", 32'(overrun), 32'(exp_ovr));
    check("overrun_rx_not_empty", 32'(rx_empty), 32'(0));
    auto_read = 1'b1;
    repeat (3) @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'(0));
    wait_rx_drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
